// File: rtl/mux_n_reg_pkg.sv
// Shared definitions for mux_n_reg: select-width helper, scan wrap point,
// parity helper and the select-update action encoding.
package mux_n_reg_pkg;

    localparam int PAR_MAX_W = 256;

    typedef enum logic [1:0] {
        SEL_HOLD   = 2'd0,
        SEL_LOAD   = 2'd1,
        SEL_REJECT = 2'd2,
        SEL_SCAN   = 2'd3
    } sel_action_e;

    function automatic int sel_width(input int channels);
        return (channels < 2) ? 1 : $clog2(channels);
    endfunction

    // The scan wraps at the last real channel, not at the select field's maximum.
    function automatic int scan_last(input int channels);
        return channels - 1;
    endfunction

    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/mux_n_reg_if.sv
// Channel bus for mux_n_reg; the mux_par signal exists only when
// MUX_N_REG_PARITY_EN is defined.
interface mux_n_reg_if #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 4
);
    import mux_n_reg_pkg::*;

    localparam int SEL_W = sel_width(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] mux_in;
    logic [SEL_W-1:0]          sel_in;
    logic                      sel_load;
    logic                      scan_mode;
    logic                      enable;
    logic [WIDTH-1:0]          mux_out;
    logic                      out_valid;
    logic [SEL_W-1:0]          cur_sel;
    logic                      sel_err;
`ifdef MUX_N_REG_PARITY_EN
    logic                      mux_par;

    modport master (
        output mux_in, sel_in, sel_load, scan_mode, enable,
        input  mux_out, out_valid, cur_sel, sel_err, mux_par
    );

    modport slave (
        input  mux_in, sel_in, sel_load, scan_mode, enable,
        output mux_out, out_valid, cur_sel, sel_err, mux_par
    );
`else
    modport master (
        output mux_in, sel_in, sel_load, scan_mode, enable,
        input  mux_out, out_valid, cur_sel, sel_err
    );

    modport slave (
        input  mux_in, sel_in, sel_load, scan_mode, enable,
        output mux_out, out_valid, cur_sel, sel_err
    );
`endif

endinterface

// File: rtl/mux_n_reg_sel_ctrl.sv
// Select register for mux_n_reg: load/scan priority, range check, sel_err pulse
// and a flag telling the output stage that the select changes at this edge.
module mux_n_reg_sel_ctrl
    import mux_n_reg_pkg::*;
#(
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = sel_width(CHANNELS)
) (
    input  logic             sysclk,
    input  logic             sys_rst,
    input  logic [SEL_W-1:0] sel_in,
    input  logic             sel_load,
    input  logic             scan_mode,
    input  logic             enable,
    output logic [SEL_W-1:0] cur_sel,
    output logic             sel_err,
    output logic             sel_change
);

    localparam logic [SEL_W:0]   CHAN_LIMIT = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(scan_last(CHANNELS));

    sel_action_e      action;
    logic [SEL_W-1:0] next_sel;
    logic             in_range;

    assign in_range = {1'b0, sel_in} < CHAN_LIMIT;

    // A load, even a rejected one, blocks the scan advance for that edge.
    always_comb begin
        action   = SEL_HOLD;
        next_sel = cur_sel;
        if (sel_load) begin
            action = in_range ? SEL_LOAD : SEL_REJECT;
        end else if (scan_mode && enable) begin
            action = SEL_SCAN;
        end
        case (action)
            SEL_LOAD: next_sel = sel_in;
            SEL_SCAN: next_sel = (cur_sel == LAST_SEL) ? '0 : cur_sel + SEL_W'(1);
            default:  next_sel = cur_sel;
        endcase
    end

    assign sel_change = (next_sel != cur_sel);

    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            cur_sel <= '0;
            sel_err <= 1'b0;
        end else begin
            cur_sel <= next_sel;
            sel_err <= (action == SEL_REJECT);
        end
    end

endmodule

// File: rtl/mux_n_reg.sv
// Registered N-channel multiplexer with held/scanned select and settle-aware
// out_valid. Defining MUX_N_REG_PARITY_EN adds the registered mux_par output.
module mux_n_reg
    import mux_n_reg_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 4
) (
    input  logic        sysclk,
    input  logic        sys_rst,
    mux_n_reg_if.slave  bus
);

    localparam int SEL_W    = sel_width(CHANNELS);
    localparam int SEL_SPAN = 1 << SEL_W;

    logic [WIDTH-1:0] chan [SEL_SPAN];
    logic [SEL_W-1:0] cur_sel;
    logic             sel_change;
    logic [WIDTH-1:0] mux_q;
    logic             valid_q;

    // Unused select codes read as zero so the channel table is fully populated.
    for (genvar c = 0; c < SEL_SPAN; c++) begin : g_chan
        if (c < CHANNELS) begin : g_real
            assign chan[c] = bus.mux_in[c*WIDTH +: WIDTH];
        end else begin : g_pad
            assign chan[c] = '0;
        end
    end

    mux_n_reg_sel_ctrl #(
        .CHANNELS (CHANNELS)
    ) u_sel_ctrl (
        .sysclk     (sysclk),
        .sys_rst    (sys_rst),
        .sel_in     (bus.sel_in),
        .sel_load   (bus.sel_load),
        .scan_mode  (bus.scan_mode),
        .enable     (bus.enable),
        .cur_sel    (cur_sel),
        .sel_err    (bus.sel_err),
        .sel_change (sel_change)
    );

    // The output samples with the pre-edge select; a select change means the
    // registered data no longer matches cur_sel for one cycle.
    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            mux_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            if (bus.enable) begin
                mux_q <= chan[cur_sel];
            end
            valid_q <= bus.enable && !sel_change;
        end
    end

    assign bus.cur_sel   = cur_sel;
    assign bus.mux_out   = mux_q;
    assign bus.out_valid = valid_q;

`ifdef MUX_N_REG_PARITY_EN
    logic par_q;

    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            par_q <= 1'b0;
        end else if (bus.enable) begin
            par_q <= even_parity(PAR_MAX_W'(chan[cur_sel]));
        end
    end

    assign bus.mux_par = par_q;
`endif

endmodule

// File: tb/tb_mux_n_reg.sv
// Self-checking bench for mux_n_reg (3 channels x 8 bits): directed literal
// checks plus randomized traffic against a behavioural model.
module tb_mux_n_reg;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 3;

    logic sysclk = 1'b0;
    logic sys_rst;

    int checks = 0;
    int errors = 0;

    mux_n_reg_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

    mux_n_reg #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .sysclk  (sysclk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sysclk = ~sysclk;

    // Behavioural model state.
    bit   model_known = 1'b0;
    int   m_sel   = 0;
    int   m_out   = 0;
    bit   m_valid = 1'b0;
    bit   m_err   = 1'b0;
    bit   m_par   = 1'b0;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input logic rst, input logic [CHANNELS*WIDTH-1:0] data,
                                  input int sel, input logic load, input logic scan,
                                  input logic en);
        @(negedge sysclk);
        sys_rst       = rst;
        bus.mux_in    = data;
        bus.sel_in    = 2'(sel);
        bus.sel_load  = load;
        bus.scan_mode = scan;
        bus.enable    = en;
        @(posedge sysclk);
        #2;
    endtask

    // Model: the rules applied to integers at each rising edge.
    always @(posedge sysclk) begin
        int  old_sel;
        int  req;
        if (sys_rst) begin
            model_known = 1'b1;
            m_sel   = 0;
            m_out   = 0;
            m_valid = 1'b0;
            m_err   = 1'b0;
            m_par   = 1'b0;
        end else if (model_known) begin
            old_sel = m_sel;
            req     = int'(bus.sel_in);
            m_err   = bus.sel_load && (req >= CHANNELS);
            if (bus.enable) begin
                m_out = int'(bus.mux_in[old_sel*WIDTH +: WIDTH]);
                m_par = ^m_out[WIDTH-1:0];
            end
            if (bus.sel_load) begin
                if (req < CHANNELS) m_sel = req;
            end else if (bus.scan_mode && bus.enable) begin
                m_sel = (old_sel + 1) % CHANNELS;
            end
            m_valid = bus.enable && (m_sel == old_sel);
        end
    end

    always @(negedge sysclk) begin
        if (model_known) begin
            check_output("cmp_cur_sel",   int'(bus.cur_sel),   m_sel);
            check_output("cmp_mux_out",   int'(bus.mux_out),   m_out);
            check_output("cmp_out_valid", int'(bus.out_valid), int'(m_valid));
            check_output("cmp_sel_err",   int'(bus.sel_err),   int'(m_err));
`ifdef MUX_N_REG_PARITY_EN
            check_output("cmp_mux_par",   int'(bus.mux_par),   int'(m_par));
`endif
        end
    end

    localparam logic [23:0] ABC = {8'hCC, 8'hBB, 8'hAA};

    initial begin
        int exp_sel [4] = '{1, 2, 0, 1};
        int exp_out [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hAA};

        // Reset with every input driven high.
        apply_stimulus(1'b1, '1, 3, 1'b1, 1'b1, 1'b1);
        apply_stimulus(1'b1, '1, 3, 1'b1, 1'b1, 1'b1);
        check_output("t1_cur_sel",   int'(bus.cur_sel),   0);
        check_output("t1_mux_out",   int'(bus.mux_out),   0);
        check_output("t1_out_valid", int'(bus.out_valid), 0);
        check_output("t1_sel_err",   int'(bus.sel_err),   0);

        // Load with one-cycle settle.
        apply_stimulus(1'b0, ABC, 0, 1'b0, 1'b0, 1'b1);
        check_output("t2_idle_out",   int'(bus.mux_out),   8'hAA);
        check_output("t2_idle_valid", int'(bus.out_valid), 1);
        apply_stimulus(1'b0, ABC, 2, 1'b1, 1'b0, 1'b1);
        check_output("t2_load_sel",   int'(bus.cur_sel),   2);
        check_output("t2_settle",     int'(bus.out_valid), 0);
        apply_stimulus(1'b0, ABC, 0, 1'b0, 1'b0, 1'b1);
        check_output("t2_out_cc",     int'(bus.mux_out),   8'hCC);
        check_output("t2_valid",      int'(bus.out_valid), 1);

        // Out-of-range load and same-value load.
        apply_stimulus(1'b0, ABC, 3, 1'b1, 1'b0, 1'b1);
        check_output("t3_err",        int'(bus.sel_err),   1);
        check_output("t3_sel_kept",   int'(bus.cur_sel),   2);
        check_output("t3_no_settle",  int'(bus.out_valid), 1);
        apply_stimulus(1'b0, ABC, 2, 1'b1, 1'b0, 1'b1);
        check_output("t3_err_clear",  int'(bus.sel_err),   0);
        check_output("t3_same_load",  int'(bus.out_valid), 1);

        // Scan wraps at CHANNELS-1; disable freezes everything.
        apply_stimulus(1'b0, ABC, 0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, ABC, 0, 1'b0, 1'b1, 1'b1);
            check_output($sformatf("t4_scan_sel%0d", i), int'(bus.cur_sel), exp_sel[i]);
            check_output($sformatf("t4_scan_out%0d", i), int'(bus.mux_out), exp_out[i]);
            check_output($sformatf("t4_scan_vld%0d", i), int'(bus.out_valid), 0);
        end
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(1'b0, ABC, 0, 1'b0, 1'b1, 1'b0);
            check_output("t4_hold_sel",   int'(bus.cur_sel),   1);
            check_output("t4_hold_out",   int'(bus.mux_out),   8'hAA);
            check_output("t4_hold_valid", int'(bus.out_valid), 0);
        end
        apply_stimulus(1'b0, ABC, 0, 1'b0, 1'b0, 1'b1);
        check_output("t4_resume_out", int'(bus.mux_out),   8'hBB);
        check_output("t4_resume_vld", int'(bus.out_valid), 1);

        // Priority: load beats scan, reset beats load.
        apply_stimulus(1'b0, ABC, 0, 1'b1, 1'b1, 1'b1);
        check_output("t5_load_wins",  int'(bus.cur_sel), 0);
        apply_stimulus(1'b1, ABC, 2, 1'b1, 1'b1, 1'b1);
        check_output("t5_rst_wins",   int'(bus.cur_sel), 0);
        check_output("t5_rst_out",    int'(bus.mux_out), 0);

        // Parity-oriented data.
        apply_stimulus(1'b0, {8'h00, 8'h33, 8'hB5}, 0, 1'b0, 1'b0, 1'b1);
        check_output("t6_out_b5", int'(bus.mux_out), 8'hB5);
`ifdef MUX_N_REG_PARITY_EN
        check_output("t6_par_b5", int'(bus.mux_par), 1);
`endif
        apply_stimulus(1'b0, {8'h00, 8'h33, 8'hB5}, 1, 1'b1, 1'b0, 1'b1);
        apply_stimulus(1'b0, {8'h00, 8'h33, 8'hB5}, 0, 1'b0, 1'b0, 1'b1);
        check_output("t6_out_33", int'(bus.mux_out), 8'h33);
`ifdef MUX_N_REG_PARITY_EN
        check_output("t6_par_33", int'(bus.mux_par), 0);
`endif

        // Randomized traffic checked by the model.
        for (int i = 0; i < 600; i++) begin
            apply_stimulus($urandom_range(31) == 0,
                           24'($urandom),
                           int'($urandom_range(3)),
                           $urandom_range(3) == 0,
                           1'($urandom_range(1)),
                           $urandom_range(3) != 0);
        end

        @(negedge sysclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
